// File: rtl/piano_pkg.sv
// Shared definitions for the piano PWM tone path: decoder FSM states and the
// frame/duty constants common to the generator and the decoder.
package piano_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2
  } state_t;

  localparam int PWM_PERIOD = 1024;
  localparam int DUTY_W     = 10;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous line followed by a registered
// edge detector; level, rise and fall are aligned to the same cycle.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // stages p0/p1: metastability filter
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      // stage p2: delayed copy, edges compare p1 against it
      level   <= sync_p1;
      rise    <= sync_p1 & ~level;
      fall    <= ~sync_p1 & level;
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the 10-bit compare value from a piano PWM line by timing the high
// phase and the rise-to-rise frame length; reports bad frames and stuck lines.
module pwm_duty_decoder
  import piano_pkg::*;
#(
  parameter int PERIOD  = PWM_PERIOD,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 2048,
  parameter int CNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              period_err,
  output logic              stuck
);

  localparam logic [DUTY_W-1:0] DUTY_FULL = '1;
  localparam logic [CNT_W-1:0]  DUTY_MAX  = {{(CNT_W-DUTY_W){1'b0}}, DUTY_FULL};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  PER_LO    = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0]  PER_HI    = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [CNT_W-1:0] v);
    return (v > DUTY_MAX) ? DUTY_FULL : v[DUTY_W-1:0];
  endfunction

  function automatic logic frame_ok(input logic [CNT_W-1:0] per);
    return (per >= PER_LO) && (per <= PER_HI);
  endfunction

  logic level_p2;
  logic rise_p2;
  logic fall_p2;
  logic edge_p2;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pwm_in),
    .level    (level_p2),
    .rise     (rise_p2),
    .fall     (fall_p2)
  );

  assign edge_p2 = rise_p2 | fall_p2;

  state_t           state;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      hi_cnt     <= '0;
      per_cnt    <= '0;
      idle_cnt   <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      // stage p3: measurement and strobes, one cycle after the synchronized edge
      duty_valid <= 1'b0;
      period_err <= 1'b0;

      case (state)
        SEARCH: begin
          if (rise_p2) begin
            hi_cnt  <= CNT_ONE;
            per_cnt <= CNT_ONE;
            state   <= HIGH;
          end
        end
        HIGH: begin
          per_cnt <= sat_inc(per_cnt);
          if (fall_p2) begin
            state <= LOW;
          end else begin
            hi_cnt <= sat_inc(hi_cnt);
          end
        end
        LOW: begin
          if (rise_p2) begin
            if (frame_ok(per_cnt)) begin
              duty       <= sat_duty(hi_cnt);
              duty_valid <= 1'b1;
            end else begin
              period_err <= 1'b1;
            end
            // the closing rise also opens the next frame
            hi_cnt  <= CNT_ONE;
            per_cnt <= CNT_ONE;
            state   <= HIGH;
          end else begin
            per_cnt <= sat_inc(per_cnt);
          end
        end
        default: state <= SEARCH;
      endcase

      // Placed after the FSM so a timeout overrides its state update.
      if (edge_p2) begin
        idle_cnt <= '0;
        stuck    <= 1'b0;
      end else begin
        idle_cnt <= sat_inc(idle_cnt);
        if (idle_cnt == IDLE_LAST) begin
          stuck      <= 1'b1;
          duty       <= level_p2 ? DUTY_FULL : '0;
          duty_valid <= 1'b1;
          state      <= SEARCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: a frame table with hand-computed
// results, then stuck-line and mid-frame reset sequences.
module tb_pwm_duty_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [9:0] duty;
  logic       duty_valid;
  logic       period_err;
  logic       stuck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;

  int dv_cyc[$];
  int dv_val[$];
  int pe_cyc[$];
  int pe_duty[$];

  pwm_duty_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .period_err (period_err),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (duty_valid || period_err)
      check("strobe_exclusive", int'(duty_valid & period_err), 0);
    if (duty_valid) begin
      dv_cyc.push_back(cyc);
      dv_val.push_back(int'(duty));
    end
    if (period_err) begin
      pe_cyc.push_back(cyc);
      pe_duty.push_back(int'(duty));
    end
  end

  task automatic clear_logs();
    dv_cyc.delete();
    dv_val.delete();
    pe_cyc.delete();
    pe_duty.delete();
  endtask

  // Drive level v for n clk cycles, changing on the falling edge.
  task automatic hold(input logic v, input int n);
    @(negedge clk);
    if (v && !pwm_in) last_rise = cyc;
    pwm_in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  function automatic int find_dv(input int c);
    for (int k = 0; k < dv_cyc.size(); k++)
      if (dv_cyc[k] == c) return k;
    return -1;
  endfunction

  function automatic int find_pe(input int c);
    for (int k = 0; k < pe_cyc.size(); k++)
      if (pe_cyc[k] == c) return k;
    return -1;
  endfunction

  typedef struct {
    int hi;
    int lo;
    bit exp_dv;
    bit exp_pe;
    int exp_duty;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl[NV];
  int   rise_at[NV+1];

  initial begin
    int held;
    int n_dv;
    int n_pe;
    int idx;
    int t_fall;
    int t_rise;
    int t_a;
    int t_b;

    tbl[0]  = '{300, 724, 1'b1, 1'b0, 300};
    tbl[1]  = '{300, 724, 1'b1, 1'b0, 300};
    tbl[2]  = '{300, 724, 1'b1, 1'b0, 300};
    tbl[3]  = '{300, 724, 1'b1, 1'b0, 300};
    tbl[4]  = '{300, 724, 1'b1, 1'b0, 300};
    tbl[5]  = '{100, 800, 1'b0, 1'b1, 0};
    tbl[6]  = '{500, 524, 1'b1, 1'b0, 500};
    tbl[7]  = '{1026, 2, 1'b1, 1'b0, 1023};
    tbl[8]  = '{1020, 4, 1'b1, 1'b0, 1020};
    tbl[9]  = '{512, 512, 1'b1, 1'b0, 512};
    tbl[10] = '{100, 924, 1'b1, 1'b0, 100};
    tbl[11] = '{400, 628, 1'b1, 1'b0, 400};
    tbl[12] = '{400, 629, 1'b0, 1'b1, 0};
    tbl[13] = '{400, 620, 1'b1, 1'b0, 400};
    tbl[14] = '{400, 619, 1'b0, 1'b1, 0};
    tbl[15] = '{300, 724, 1'b1, 1'b0, 300};

    // Reset state
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("reset_duty", int'(duty), 0);
    check("reset_duty_valid", int'(duty_valid), 0);
    check("reset_period_err", int'(period_err), 0);
    check("reset_stuck", int'(stuck), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();

    // Frame table: each frame is reported at the rise that ends it
    for (int i = 0; i < NV; i++) begin
      hold(1'b1, tbl[i].hi);
      rise_at[i] = last_rise;
      hold(1'b0, tbl[i].lo);
    end
    hold(1'b1, 20);
    rise_at[NV] = last_rise;

    held = 0;
    n_dv = 0;
    n_pe = 0;
    check("no_strobe_first_rise", find_dv(rise_at[0] + 4) + find_pe(rise_at[0] + 4), -2);
    for (int i = 0; i < NV; i++) begin
      idx = find_dv(rise_at[i+1] + 4);
      check($sformatf("vec%0d_duty_valid", i), int'(idx >= 0), int'(tbl[i].exp_dv));
      if (tbl[i].exp_dv) begin
        n_dv++;
        held = tbl[i].exp_duty;
        if (idx >= 0) check($sformatf("vec%0d_duty", i), dv_val[idx], tbl[i].exp_duty);
      end
      idx = find_pe(rise_at[i+1] + 4);
      check($sformatf("vec%0d_period_err", i), int'(idx >= 0), int'(tbl[i].exp_pe));
      if (tbl[i].exp_pe) begin
        n_pe++;
        if (idx >= 0) check($sformatf("vec%0d_duty_held", i), pe_duty[idx], held);
      end
    end
    check("table_dv_count", dv_cyc.size(), n_dv);
    check("table_pe_count", pe_cyc.size(), n_pe);

    // Stuck low after a normal high phase
    hold(1'b1, 280);
    clear_logs();
    hold(1'b0, 3000);
    t_fall = last_rise;
    t_fall = cyc - 2999;
    check("stuck_low_level", int'(stuck), 1);
    check("stuck_low_duty", int'(duty), 0);
    check("stuck_low_dv_count", dv_cyc.size(), 1);
    if (dv_cyc.size() == 1) begin
      check("stuck_low_dv_time", dv_cyc[0], t_fall + 2052);
      check("stuck_low_dv_value", dv_val[0], 0);
    end
    check("stuck_low_pe_count", pe_cyc.size(), 0);

    // Stuck high
    clear_logs();
    hold(1'b1, 10);
    t_rise = last_rise;
    check("stuck_clear_on_rise", int'(stuck), 0);
    hold(1'b1, 2990);
    check("stuck_high_level", int'(stuck), 1);
    check("stuck_high_duty", int'(duty), 1023);
    check("stuck_high_dv_count", dv_cyc.size(), 1);
    if (dv_cyc.size() == 1) begin
      check("stuck_high_dv_time", dv_cyc[0], t_rise + 2052);
      check("stuck_high_dv_value", dv_val[0], 1023);
    end
    hold(1'b0, 10);
    check("stuck_clear_on_fall", int'(stuck), 0);

    // Reset 200 cycles into a high phase
    hold(1'b1, 500);
    hold(1'b0, 524);
    hold(1'b1, 200);
    check("pre_reset_duty", int'(duty), 500);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_duty", int'(duty), 0);
    check("midreset_duty_valid", int'(duty_valid), 0);
    check("midreset_period_err", int'(period_err), 0);
    check("midreset_stuck", int'(stuck), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    hold(1'b1, 298);
    hold(1'b0, 524);
    hold(1'b1, 500);
    t_a = last_rise;
    hold(1'b0, 524);
    hold(1'b1, 20);
    t_b = last_rise;
    repeat (8) @(negedge clk);
    check("postreset_no_dv_first_rise", find_dv(t_a + 4), -1);
    check("postreset_partial_rejected", int'(find_pe(t_a + 4) >= 0), 1);
    check("postreset_dv_count", dv_cyc.size(), 1);
    idx = find_dv(t_b + 4);
    check("postreset_dv_second_rise", int'(idx >= 0), 1);
    if (idx >= 0) check("postreset_duty", dv_val[idx], 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
